slice_cfg_loader: RTL and testbench
===================================

// Module: slice_cfg_loader
// PURPOSE
//  Configuration-side driver for one logic slice. Accepts a word-serial config
//  stream over a valid/ready handshake and assembles the full slice frame: all
//  LUT config words plus the carry-chain enable bit. Presents the frame
//  atomically and pulses cen for one cclk cycle so the slice captures it.
//  Sits between the fabric config bus and each slice's config ports.
// PARAMETERS
//  S_XX_BASE  4                  LUT input-count base; must match slice
//  CFG_SIZE   2**S_XX_BASE+1     config bits per LUT half; LUT frame = 2*CFG_SIZE
//  NUM_LUTS   4                  LUTs per slice
//  WORD_W     8                  stream word width
//  (derived) FRAME_W = NUM_LUTS*2*CFG_SIZE+1 (137); NWORDS = ceil(FRAME_W/WORD_W) (18)
// PORTS
//  cclk             in   1                   config clock; the only clock
//  rst_n            in   1                   async active-low reset
//  start            in   1                   pulse: begin new frame load
//  in_data          in   WORD_W              stream word
//  in_valid         in   1                   in_data valid
//  in_ready         out  1                   loader accepts word
//  luts_config_out  out  NUM_LUTS*2*CFG_SIZE LUT i at [(i+1)*2*CFG_SIZE-1 : i*2*CFG_SIZE]
//  config_use_cc    out  1                   carry-chain enable for slice
//  cen              out  1                   config capture enable to slice
//  busy             out  1                   state != IDLE
//  done             out  1                   one-cycle pulse after frame applied
//  cfg_err          out  1                   checksum fail, sticky (SLICE_CFG_CHK_EN only)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; all outputs 0; staging reg and word count cleared.
//  - Word accepted on cclk edge when in_valid & in_ready. Word k fills frame bits
//    [k*WORD_W +: WORD_W], LSB first. Bits >= FRAME_W in the last word are dropped.
//  - Frame map: bit 0 = use_cc; bits [1+i*2*CFG_SIZE +: 2*CFG_SIZE] = LUT i.
//  - FSM:
//    IDLE: in_ready=0. start -> LOAD; count=0; staging cleared; cfg_err cleared.
//    LOAD: in_ready=1. Accept -> count++. Accept of word NWORDS-1 -> APPLY,
//          or -> CHECK when SLICE_CFG_CHK_EN is defined.
//          start in LOAD: abort, count=0, staging cleared, stay in LOAD.
//    CHECK: in_ready=1 for one extra checksum word. Equal to XOR of all NWORDS
//          data words -> APPLY. Mismatch -> IDLE, cfg_err=1, outputs unchanged,
//          cen stays 0. start in CHECK behaves as in LOAD (-> LOAD).
//    APPLY: entered on the edge that loads luts_config_out/config_use_cc from
//          staging and sets cen=1. Lasts exactly 1 cycle. in_ready=0. start ignored.
//          Next edge: cen=0, done=1 for 1 cycle, -> IDLE.
//  - Slice captures on the edge that ends APPLY. Outputs are stable for the
//    full cen-high cycle and hold until the next APPLY.
//  - Latency: last word (or checksum) accepted at edge N -> cen high in cycle
//    N..N+1 -> done high in cycle N+1..N+2.
//  - in_valid with in_ready=0 is ignored; no word is consumed.
//  - Reset during LOAD/APPLY: immediate abort. cen and done drop to 0 asynchronously.
//  - busy=1 in LOAD, CHECK and APPLY.
// CONFIGURATION
//  SLICE_CFG_CHK_EN defined: CHECK state and cfg_err active; each frame is
//   NWORDS data words plus 1 XOR checksum word.
//  Not defined: no CHECK state; LOAD -> APPLY directly; cfg_err tied 0;
//   frame is exactly NWORDS words.
// TESTING
//  1. Reset, start, 18 words 0x01..0x12, in_valid held high -> in_ready high 18
//     cycles; cen high 1 cycle; config_use_cc=1; LUT0 bits [7:0] = 0x00 after the
//     shift by 1 (bit0 of word0 = use_cc); done pulses 1 cycle after cen.
//  2. Random in_valid gaps (~50%) on the same frame -> identical outputs to
//     scenario 1; exactly 18 handshakes.
//  3. start after 7 words, then a full 18-word frame of 0xFF -> all LUT bits 1;
//     use_cc=1; words from the aborted partial frame have no effect.
//  4. rst_n low mid-LOAD (word 10) -> all outputs 0 immediately; cen never pulses;
//     the next full frame loads correctly.
//  5. (CHK_EN) 18 words plus correct XOR -> cen pulse. 18 words plus XOR^0x01 ->
//     cfg_err=1; no cen; outputs keep prior frame; next start clears cfg_err.
//  6. Words 0xAA in IDLE with in_valid=1, no start -> in_ready=0; outputs and busy
//     unchanged.

Source files
------------

// File: rtl/slice_cfg_loader.sv
// slice_cfg_loader: assembles a word-serial slice frame and applies it with a one-cycle cen.
// Define SLICE_CFG_CHK_EN to require and verify a trailing XOR checksum word per frame.
module slice_cfg_loader #(
   parameter int S_XX_BASE = 4,
   parameter int CFG_SIZE  = 2**S_XX_BASE + 1,
   parameter int NUM_LUTS  = 4,
   parameter int WORD_W    = 8
) (
   input  logic                           cclk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [WORD_W-1:0]              in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [NUM_LUTS*2*CFG_SIZE-1:0] luts_config_out,
   output logic                           config_use_cc,
   output logic                           cen,
   output logic                           busy,
   output logic                           done,
   output logic                           cfg_err
);
   localparam int FRAME_W = NUM_LUTS*2*CFG_SIZE + 1;
   localparam int NWORDS  = (FRAME_W + WORD_W - 1) / WORD_W;
   localparam int LAST_W  = FRAME_W - (NWORDS - 1)*WORD_W;
   localparam int CW      = $clog2(NWORDS + 1);

   typedef enum logic [1:0] {IDLE, LOAD, CHECK, APPLY} state_t;
`ifdef SLICE_CFG_CHK_EN
   localparam state_t AFTER_LOAD = CHECK;
   logic [WORD_W-1:0] xsum;
`else
   localparam state_t AFTER_LOAD = APPLY;
`endif

   state_t             state, state_n;
   logic [CW-1:0]      count;
   logic [FRAME_W-1:0] staging, shifted, frame;
   logic               accept, last;

   assign accept = in_valid & in_ready;
   assign last   = count == CW'(NWORDS - 1);
   // Words enter at the top; the final word shifts by its kept width only, so word k lands at k*WORD_W
   assign shifted = last ? {in_data[LAST_W-1:0], staging[FRAME_W-1:LAST_W]}
                         : {in_data, staging[FRAME_W-1:WORD_W]};
   assign frame = (state == LOAD) ? shifted : staging;
   assign cen   = state == APPLY;
   assign busy  = state != IDLE;

   always_ff @(posedge cclk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_n;

   always_comb begin
      state_n  = state;
      in_ready = 1'b0;
      case (state)
         IDLE: state_n = start ? LOAD : IDLE;
         LOAD: begin
            in_ready = 1'b1;
            state_n  = (!start && accept && last) ? AFTER_LOAD : LOAD;
         end
`ifdef SLICE_CFG_CHK_EN
         CHECK: begin
            in_ready = 1'b1;
            state_n  = start ? LOAD : !accept ? CHECK : (in_data == xsum) ? APPLY : IDLE;
         end
`endif
         APPLY:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge cclk or negedge rst_n)
      if (!rst_n) begin
         count           <= '0;
         staging         <= '0;
         luts_config_out <= '0;
         config_use_cc   <= 1'b0;
         done            <= 1'b0;
         cfg_err         <= 1'b0;
`ifdef SLICE_CFG_CHK_EN
         xsum            <= '0;
`endif
      end else begin
         done <= cen;
         if (start && state != APPLY) begin
            count   <= '0;
            staging <= '0;
            cfg_err <= 1'b0;
`ifdef SLICE_CFG_CHK_EN
            xsum    <= '0;
`endif
         end else if (accept && state == LOAD) begin
            count   <= count + 1'b1;
            staging <= shifted;
`ifdef SLICE_CFG_CHK_EN
            xsum    <= xsum ^ in_data;
         end else if (accept && state == CHECK && in_data != xsum) begin
            cfg_err <= 1'b1;
`endif
         end
         if (state_n == APPLY) {luts_config_out, config_use_cc} <= frame;
      end
endmodule

// File: tb/tb_slice_cfg_loader.sv
// tb_slice_cfg_loader: scoreboard bench; expected frames are queued at start and popped on cen.
module tb_slice_cfg_loader;
   localparam int NW = 18;

   logic         cclk = 1'b0, rst_n = 1'b1, start = 1'b0, in_valid = 1'b0;
   logic [7:0]   in_data = 8'h00;
   logic         in_ready, config_use_cc, cen, busy, done, cfg_err;
   logic [135:0] luts;

   int           checks = 0, failures = 0, hs = 0;
   logic         prev_cen = 1'b0;
   logic [136:0] sbq[$];
   logic [136:0] last_exp = '0;
   logic [7:0]   fw[NW];
   logic [7:0]   base[NW];

   slice_cfg_loader dut (
      .cclk(cclk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .luts_config_out(luts), .config_use_cc(config_use_cc),
      .cen(cen), .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   always #5 cclk = ~cclk;

   task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [136:0] model();
      logic [143:0] f = '0;
      for (int k = 0; k < NW; k++) f[k*8 +: 8] = fw[k];
      return f[136:0];
   endfunction

   function automatic logic [7:0] xor_all();
      logic [7:0] x = 8'h00;
      for (int k = 0; k < NW; k++) x ^= fw[k];
      return x;
   endfunction

   // handshakes and cen/done behaviour are observed on the falling edge
   always @(negedge cclk) begin
      if (rst_n && in_valid && in_ready) hs++;
      if (cen) begin
         if (sbq.size() == 0) chk("unexpected_cen", cen, 0);
         else begin
            logic [136:0] e;
            e = sbq.pop_front();
            chk("luts", luts, e[136:1]);
            chk("use_cc", config_use_cc, e[0]);
            chk("apply_ready", in_ready, 0);
         end
      end
      if (prev_cen || done) chk("done_pulse", done, prev_cen);
      prev_cen = cen;
   end

   task automatic cyc();
      @(posedge cclk);
      #1;
   endtask

   task automatic send_word(input logic [7:0] w, input bit gaps);
      int n = 0;
      if (gaps)
         while (n < 8 && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            cyc();
            n++;
         end
      in_data  = w;
      in_valid = 1'b1;
      n = 0;
      @(negedge cclk);
      while (!in_ready && n < 100) begin
         @(negedge cclk);
         n++;
      end
      if (!in_ready) chk("ready_timeout", in_ready, 1);
      cyc();
   endtask

   task automatic pulse_start();
      in_valid = 1'b0;
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic run_frame(input bit gaps, input bit good);
      logic [136:0] e;
      int h0;
      e = model();
      pulse_start();
      chk("cfg_err_clear", cfg_err, 0);
      chk("busy_load", busy, 1);
      if (good) sbq.push_back(e);
      h0 = hs;
      for (int k = 0; k < NW; k++) send_word(fw[k], gaps);
`ifdef SLICE_CFG_CHK_EN
      send_word(good ? xor_all() : xor_all() ^ 8'h01, gaps);
`endif
      in_valid = 1'b0;
      @(negedge cclk);
      chk("cen_latency", cen, good);
      chk("cfg_err", cfg_err, !good);
      if (!good) chk("luts_hold", {luts, config_use_cc}, last_exp);
      @(negedge cclk);
      chk("done", done, good);
      chk("busy_after", busy, 0);
`ifdef SLICE_CFG_CHK_EN
      chk("handshakes", hs - h0, NW + 1);
`else
      chk("handshakes", hs - h0, NW);
`endif
      if (good) last_exp = e;
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < NW; k++) base[k] = 8'(k + 1);
      #2 rst_n = 1'b0;
      @(negedge cclk);
      chk("rst_luts", luts, 0);
      chk("rst_use_cc", config_use_cc, 0);
      chk("rst_cen", cen, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_cfg_err", cfg_err, 0);
      cyc();
      rst_n = 1'b1;
      cyc();

      // 1: words 0x01..0x12, valid held high
      fw = base;
      run_frame(0, 1);
      chk("use_cc_s1", config_use_cc, 1);
      chk("lut0_low", luts[7:0], 8'h00);

      // 2: same frame with random valid gaps
      run_frame(1, 1);

      // 2b: random frame with gaps
      for (int k = 0; k < NW; k++) fw[k] = 8'($urandom);
      run_frame(1, 1);

      // 3: abort after 7 words, then all-ones frame
      pulse_start();
      for (int k = 0; k < 7; k++) send_word(8'($urandom), 0);
      in_valid = 1'b0;
      for (int k = 0; k < NW; k++) fw[k] = 8'hFF;
      run_frame(0, 1);
      chk("all_ones", luts, {136{1'b1}});

      // 4: reset mid-load after 10 words
      fw = base;
      pulse_start();
      for (int k = 0; k < 10; k++) send_word(fw[k], 0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_luts", luts, 0);
      chk("mid_rst_use_cc", config_use_cc, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_cen", cen, 0);
      chk("mid_rst_ready", in_ready, 0);
      repeat (3) cyc();
      rst_n = 1'b1;
      last_exp = '0;
      cyc();
      run_frame(0, 1);

`ifdef SLICE_CFG_CHK_EN
      // 5: bad checksum keeps prior frame, next start clears cfg_err
      for (int k = 0; k < NW; k++) fw[k] = 8'($urandom);
      run_frame(0, 0);
      run_frame(1, 1);
`endif

      // 6: valid words in IDLE without start are ignored
      begin
         int h0;
         h0 = hs;
         in_data  = 8'hAA;
         in_valid = 1'b1;
         for (int i = 0; i < 4; i++) begin
            @(negedge cclk);
            chk("idle_ready", in_ready, 0);
            chk("idle_busy", busy, 0);
         end
         cyc();
         in_valid = 1'b0;
         chk("idle_luts", {luts, config_use_cc}, last_exp);
         chk("idle_hs", hs - h0, 0);
      end

      repeat (3) cyc();
      chk("sb_empty", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
